// File: rtl/bus_scheduler_rr_pkg.sv
`default_nettype none
// ============================================================================
// Package    : bus_sched_pkg
// Description: State encoding and id-width helper for the round-robin scheduler.
// Revision   : 1.0
// ============================================================================
package bus_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_DRIVE = ST_DRIVE,
    S_TURN  = ST_TURN,
    S_ERR   = ST_ERR
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_scheduler_rr_if.sv
`default_nettype none
// ============================================================================
// Interface  : bus_scheduler_rr_if
// Description: Request/destination inputs and enable/status outputs of the scheduler.
// Revision   : 1.0
// ============================================================================
interface bus_scheduler_rr_if #(
  parameter int N   = 2,
  parameter int IDW = 1
);
  logic [N-1:0]     req;
  logic [N*IDW-1:0] dst;
  logic [N-1:0]     enable_send;
  logic [N-1:0]     enable_receive;
  logic [N-1:0]     done;
  logic [N-1:0]     err;
  logic             busy;
  logic [IDW-1:0]   grant_id;

  modport master (
    output req, dst,
    input  enable_send, enable_receive, done, err, busy, grant_id
  );

  modport slave (
    input  req, dst,
    output enable_send, enable_receive, done, err, busy, grant_id
  );
endinterface
`default_nettype wire

// File: rtl/bus_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module     : rr_pick
// Description: Combinational round-robin picker, search order ptr+1 .. ptr (mod N).
// Revision   : 1.0
// ============================================================================
module rr_pick
  import bus_sched_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = clog2_min1(N)
) (
  input  wire logic [N-1:0]   req_i,
  input  wire logic [N-1:0]   mask_i,
  input  wire logic [IDW-1:0] ptr_i,
  output logic                valid_o,
  output logic [IDW-1:0]      id_o
);

  // Scan farthest-first so the nearest eligible agent is the last assignment.
  always_comb begin
    int idx;
    idx     = 0;
    valid_o = 1'b0;
    id_o    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx] && !mask_i[idx]) begin
        valid_o = 1'b1;
        id_o    = IDW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_scheduler_rr.sv
`default_nettype none
// ============================================================================
// Module     : bus_scheduler_rr
// Description: Round-robin single-beat scheduler for a shared tri-state bus.
// Revision   : 1.0
// ============================================================================
module bus_scheduler_rr
  import bus_sched_pkg::*;
#(
  parameter int N           = 2,
  parameter int IDW         = clog2_min1(N),
  parameter int TURN_CYCLES = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  bus_scheduler_rr_if.slave  bus_if
);

  localparam logic [1:0] TURN_LOAD = 2'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] id);
    return {{(N-1){1'b0}}, 1'b1} << id;
  endfunction

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] dst_q,   dst_d;
  logic [1:0]     cnt_q,   cnt_d;
  logic [N-1:0]   mask_q,  mask_d;

  logic [N-1:0]   w_mask;
  logic           w_pick_valid;
  logic [IDW-1:0] w_pick_id;
  logic [IDW-1:0] w_dst_sel;
  logic           w_dst_bad;
  logic           w_arb;

  // An agent that just finished is skipped once, in case its req is still high.
  assign w_mask = (state_q == S_DRIVE) ? onehot(grant_q) : mask_q;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_i   (bus_if.req),
    .mask_i  (w_mask),
    .ptr_i   (grant_q),
    .valid_o (w_pick_valid),
    .id_o    (w_pick_id)
  );

  assign w_dst_sel = bus_if.dst[int'(w_pick_id)*IDW +: IDW];
  assign w_dst_bad = (int'(w_dst_sel) >= N) || (w_dst_sel == w_pick_id);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    w_arb   = 1'b0;
    case (state_q)
      S_IDLE:  w_arb = 1'b1;
      S_DRIVE: begin
        mask_d = onehot(grant_q);
        if (TURN_CYCLES > 0) begin
          state_d = S_TURN;
          cnt_d   = TURN_LOAD;
        end else begin
          w_arb = 1'b1;
        end
      end
      S_TURN: begin
        if (cnt_q == 2'd0) w_arb = 1'b1;
        else               cnt_d = cnt_q - 2'd1;
      end
      S_ERR: begin
        state_d = S_IDLE;
        mask_d  = onehot(grant_q);
      end
      default: state_d = S_IDLE;
    endcase
    if (w_arb) begin
      mask_d = '0;
      if (w_pick_valid) begin
        grant_d = w_pick_id;
        dst_d   = w_dst_sel;
        state_d = w_dst_bad ? S_ERR : S_DRIVE;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= IDW'(N - 1);
      dst_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  assign bus_if.enable_send    = (state_q == S_DRIVE) ? onehot(grant_q) : '0;
  assign bus_if.enable_receive = (state_q == S_DRIVE) ? onehot(dst_q)   : '0;
  assign bus_if.done           = (state_q == S_DRIVE) ? onehot(grant_q) : '0;
  assign bus_if.err            = (state_q == S_ERR)   ? onehot(grant_q) : '0;
  assign bus_if.busy           = (state_q != S_IDLE);
  assign bus_if.grant_id       = grant_q;

endmodule
`default_nettype wire
